// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: default datapath widths and the register-file FSM states.
package picomips_pkg;

   localparam int unsigned N_DEF  = 8;
   localparam int unsigned AW_DEF = 3;

   typedef enum logic {IDLE, WAIT_IN} rf_state_t;

endpackage

// File: rtl/regfile_wb_if.sv
// Register-file bus: operand reads, ALU writeback, input capture handshake, LED output.
//   slave  : the register file (drives rdata_a/b, stall, out_data)
//   master : the core/decoder side (drives addresses, writeback and input signals)
interface regfile_wb_if
   import picomips_pkg::*;
#(
   parameter int unsigned N  = N_DEF,
   parameter int unsigned AW = AW_DEF
) ();

   logic [AW-1:0] raddr_a;
   logic [AW-1:0] raddr_b;
   logic [N-1:0]  rdata_a;
   logic [N-1:0]  rdata_b;
   logic          we;
   logic [AW-1:0] waddr;
   logic [N-1:0]  wdata;
   logic          in_req;
   logic          in_valid;
   logic [N-1:0]  in_data;
   logic          stall;
   logic [N-1:0]  out_data;

   modport slave (
      input  raddr_a, raddr_b, we, waddr, wdata, in_req, in_valid, in_data,
      output rdata_a, rdata_b, stall, out_data
   );

   modport master (
      output raddr_a, raddr_b, we, waddr, wdata, in_req, in_valid, in_data,
      input  rdata_a, rdata_b, stall, out_data
   );

endinterface

// File: rtl/regfile_wb.sv
// picoMIPS operand register file with ALU writeback, stalling input capture and LED mirror.
// Ports:
//   clk     : rising-edge clock
//   nReset  : synchronous active-low reset
//   bus     : regfile_wb_if.slave (read ports A/B, writeback, input capture, stall, out_data)
// Parameters: N data width, AW address width (2**AW registers), OUT_REG mirrored register.
// Optional macro WR_BYPASS_EN: same-cycle write data is forwarded to matching read ports.
module regfile_wb
   import picomips_pkg::*;
#(
   parameter int unsigned N       = N_DEF,
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned OUT_REG = 1
) (
   input  logic          clk,
   input  logic          nReset,
   regfile_wb_if.slave   bus
);

   localparam int unsigned   NREG     = 2 ** AW;
   localparam logic [AW-1:0] OUT_ADDR = AW'(OUT_REG);

   rf_state_t     state;
   logic [AW-1:0] cap_addr;
   logic [N-1:0]  regs [NREG];
   logic [N-1:0]  out_data_q;

   logic          wr_en_c;
   logic          wr_hit_c;
   logic [AW-1:0] wr_addr_c;
   logic [N-1:0]  wr_data_c;
   logic          go_wait_c;
   logic [N-1:0]  rdata_a_c;
   logic [N-1:0]  rdata_b_c;

   // Write-source selection: input capture outranks writeback; WAIT_IN ignores we/in_req.
   always_comb begin
      wr_en_c   = 1'b0;
      wr_addr_c = '0;
      wr_data_c = '0;
      go_wait_c = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_req) begin
               if (bus.in_valid) begin
                  wr_en_c   = 1'b1;
                  wr_addr_c = bus.waddr;
                  wr_data_c = bus.in_data;
               end else begin
                  go_wait_c = 1'b1;
               end
            end else if (bus.we) begin
               wr_en_c   = 1'b1;
               wr_addr_c = bus.waddr;
               wr_data_c = bus.wdata;
            end
         end
         WAIT_IN: begin
            if (bus.in_valid) begin
               wr_en_c   = 1'b1;
               wr_addr_c = cap_addr;
               wr_data_c = bus.in_data;
            end
         end
         default: ;
      endcase
      // Register 0 is hard-wired; reset suppresses any write.
      wr_hit_c = nReset && wr_en_c && (wr_addr_c != '0);
   end

   // Register array, capture FSM and out_data mirror.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         state      <= IDLE;
         cap_addr   <= '0;
         out_data_q <= '0;
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (wr_hit_c) begin
            regs[wr_addr_c] <= wr_data_c;
         end
         // Copies the stored value, so out_data trails the write edge by one cycle.
         out_data_q <= regs[OUT_ADDR];
         case (state)
            IDLE: begin
               if (go_wait_c) begin
                  state    <= WAIT_IN;
                  cap_addr <= bus.waddr;
               end
            end
            WAIT_IN: begin
               if (bus.in_valid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read ports; address 0 always reads zero and is never forwarded.
   always_comb begin
      rdata_a_c = regs[bus.raddr_a];
      rdata_b_c = regs[bus.raddr_b];
`ifdef WR_BYPASS_EN
      if (wr_hit_c && (wr_addr_c == bus.raddr_a)) rdata_a_c = wr_data_c;
      if (wr_hit_c && (wr_addr_c == bus.raddr_b)) rdata_b_c = wr_data_c;
`endif
      if (bus.raddr_a == '0) rdata_a_c = '0;
      if (bus.raddr_b == '0) rdata_b_c = '0;
   end

   assign bus.rdata_a  = rdata_a_c;
   assign bus.rdata_b  = rdata_b_c;
   // Stall rises in the same cycle an unsatisfied in_req is seen.
   assign bus.stall    = (state == WAIT_IN) || go_wait_c;
   assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: reference register model plus expected-value queue.
module tb_regfile_wb;

   logic clk;
   logic nReset;

   regfile_wb_if #(.N(8), .AW(3)) bus ();

   regfile_wb #(.N(8), .AW(3), .OUT_REG(1)) dut (
      .clk    (clk),
      .nReset (nReset),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [7:0]  model [8];
   logic [7:0]  sb [$];
   logic [7:0]  exp_v;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.raddr_a  = '0;
      bus.raddr_b  = '0;
      bus.we       = 1'b0;
      bus.waddr    = '0;
      bus.wdata    = '0;
      bus.in_req   = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   task automatic do_reset();
      nReset = 1'b0;
      tick();
      nReset = 1'b1;
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
   endtask

   task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
      bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
      tick();
      bus.we = 1'b0;
      if (a != 3'd0) model[a] = d;
   endtask

   task automatic test_reset();
      for (int i = 1; i < 8; i++) wb_write(3'(i), 8'(8'h10 + i));
      tick();
      nReset = 1'b0;
      bus.we = 1'b1; bus.waddr = 3'd5; bus.wdata = 8'hEE;
      tick();
      nReset = 1'b1;
      bus.we = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      #1;
      sb.push_back(8'h00);
      exp_v = sb.pop_front(); vectors++;
      if (bus.stall !== exp_v[0]) begin
         miscompares++;
         $display("FAIL reset_stall got=%b want=%b", bus.stall, exp_v[0]);
      end
      sb.push_back(8'h00);
      exp_v = sb.pop_front(); vectors++;
      if (bus.out_data !== exp_v) begin
         miscompares++;
         $display("FAIL reset_out_data got=%h want=%h", bus.out_data, exp_v);
      end
      for (int i = 0; i < 8; i++) begin
         bus.raddr_a = 3'(i); bus.raddr_b = 3'(7 - i);
         sb.push_back(model[i]); sb.push_back(model[7 - i]);
         #1;
         exp_v = sb.pop_front(); vectors++;
         if (bus.rdata_a !== exp_v) begin
            miscompares++;
            $display("FAIL reset_rdata_a[%0d] got=%h want=%h", i, bus.rdata_a, exp_v);
         end
         exp_v = sb.pop_front(); vectors++;
         if (bus.rdata_b !== exp_v) begin
            miscompares++;
            $display("FAIL reset_rdata_b[%0d] got=%h want=%h", 7 - i, bus.rdata_b, exp_v);
         end
      end
   endtask

   task automatic test_writeback();
      wb_write(3'd3, 8'h5A);
      bus.raddr_a = 3'd3;
      sb.push_back(model[3]);
      #1;
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_a !== exp_v || exp_v !== 8'h5A) begin
         miscompares++;
         $display("FAIL wb_reg3 got=%h want=%h", bus.rdata_a, exp_v);
      end
      wb_write(3'd0, 8'hFF);
      bus.raddr_a = 3'd0; bus.raddr_b = 3'd0;
      sb.push_back(8'h00); sb.push_back(8'h00);
      #1;
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_a !== exp_v) begin
         miscompares++;
         $display("FAIL wb_reg0_a got=%h want=%h", bus.rdata_a, exp_v);
      end
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_b !== exp_v) begin
         miscompares++;
         $display("FAIL wb_reg0_b got=%h want=%h", bus.rdata_b, exp_v);
      end
   endtask

   task automatic test_input_stall();
      bus.in_req = 1'b1; bus.waddr = 3'd2; bus.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         sb.push_back(8'h01);
         exp_v = sb.pop_front(); vectors++;
         if (bus.stall !== exp_v[0]) begin
            miscompares++;
            $display("FAIL stall_wait_c%0d got=%b want=%b", c, bus.stall, exp_v[0]);
         end
         tick();
         // While waiting, writeback and a new destination must be ignored.
         bus.we = 1'b1; bus.waddr = 3'd4; bus.wdata = 8'hEE;
      end
      bus.in_req = 1'b0; bus.we = 1'b0; bus.waddr = 3'd6;
      bus.in_valid = 1'b1; bus.in_data = 8'h33;
      #1;
      sb.push_back(8'h01);
      exp_v = sb.pop_front(); vectors++;
      if (bus.stall !== exp_v[0]) begin
         miscompares++;
         $display("FAIL stall_capture_cycle got=%b want=%b", bus.stall, exp_v[0]);
      end
      tick();
      model[2] = 8'h33;
      bus.in_valid = 1'b0;
      bus.raddr_a = 3'd2; bus.raddr_b = 3'd4;
      sb.push_back(8'h00); sb.push_back(model[2]); sb.push_back(model[4]);
      #1;
      exp_v = sb.pop_front(); vectors++;
      if (bus.stall !== exp_v[0]) begin
         miscompares++;
         $display("FAIL stall_release got=%b want=%b", bus.stall, exp_v[0]);
      end
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_a !== exp_v) begin
         miscompares++;
         $display("FAIL capture_reg2 got=%h want=%h", bus.rdata_a, exp_v);
      end
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_b !== exp_v) begin
         miscompares++;
         $display("FAIL wait_ignored_we_reg4 got=%h want=%h", bus.rdata_b, exp_v);
      end
      bus.raddr_a = 3'd6;
      sb.push_back(model[6]);
      #1;
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_a !== exp_v) begin
         miscompares++;
         $display("FAIL capture_wrong_addr_reg6 got=%h want=%h", bus.rdata_a, exp_v);
      end
   endtask

   task automatic test_direct_capture();
      // in_req with in_valid already high captures immediately and beats we.
      bus.in_req = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h77; bus.waddr = 3'd7;
      bus.we = 1'b1; bus.wdata = 8'h99;
      #1;
      sb.push_back(8'h00);
      exp_v = sb.pop_front(); vectors++;
      if (bus.stall !== exp_v[0]) begin
         miscompares++;
         $display("FAIL direct_capture_stall got=%b want=%b", bus.stall, exp_v[0]);
      end
      tick();
      model[7] = 8'h77;
      idle_inputs();
      bus.raddr_b = 3'd7;
      sb.push_back(model[7]);
      #1;
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_b !== exp_v) begin
         miscompares++;
         $display("FAIL direct_capture_reg7 got=%h want=%h", bus.rdata_b, exp_v);
      end
   endtask

   task automatic test_reset_wait();
      bus.in_req = 1'b1; bus.waddr = 3'd2; bus.in_valid = 1'b0;
      tick();
      bus.in_req = 1'b0;
      nReset = 1'b0;
      tick();
      nReset = 1'b1;
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      sb.push_back(8'h00);
      #1;
      exp_v = sb.pop_front(); vectors++;
      if (bus.stall !== exp_v[0]) begin
         miscompares++;
         $display("FAIL reset_wait_stall got=%b want=%b", bus.stall, exp_v[0]);
      end
      bus.in_valid = 1'b1; bus.in_data = 8'hAB;
      tick();
      bus.in_valid = 1'b0;
      bus.raddr_a = 3'd2;
      sb.push_back(model[2]);
      #1;
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_a !== exp_v) begin
         miscompares++;
         $display("FAIL reset_wait_no_write got=%h want=%h", bus.rdata_a, exp_v);
      end
   endtask

   task automatic test_out_data();
      logic [7:0] prev;
      prev = model[1];
      wb_write(3'd1, 8'hC3);
      sb.push_back(prev);
      exp_v = sb.pop_front(); vectors++;
      if (bus.out_data !== exp_v) begin
         miscompares++;
         $display("FAIL out_data_early got=%h want=%h", bus.out_data, exp_v);
      end
      tick();
      sb.push_back(model[1]);
      exp_v = sb.pop_front(); vectors++;
      if (bus.out_data !== exp_v) begin
         miscompares++;
         $display("FAIL out_data_wb got=%h want=%h", bus.out_data, exp_v);
      end
      bus.in_req = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h5E; bus.waddr = 3'd1;
      tick();
      idle_inputs();
      model[1] = 8'h5E;
      tick();
      sb.push_back(model[1]);
      exp_v = sb.pop_front(); vectors++;
      if (bus.out_data !== exp_v) begin
         miscompares++;
         $display("FAIL out_data_capture got=%h want=%h", bus.out_data, exp_v);
      end
   endtask

   task automatic test_bypass();
      wb_write(3'd5, 8'h22);
      bus.we = 1'b1; bus.waddr = 3'd5; bus.wdata = 8'h11; bus.raddr_b = 3'd5;
`ifdef WR_BYPASS_EN
      sb.push_back(8'h11);
`else
      sb.push_back(model[5]);
`endif
      #1;
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_b !== exp_v) begin
         miscompares++;
         $display("FAIL bypass_wb got=%h want=%h", bus.rdata_b, exp_v);
      end
      tick();
      bus.we = 1'b0;
      model[5] = 8'h11;
      sb.push_back(model[5]);
      #1;
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_b !== exp_v) begin
         miscompares++;
         $display("FAIL bypass_after got=%h want=%h", bus.rdata_b, exp_v);
      end
      bus.we = 1'b1; bus.waddr = 3'd0; bus.wdata = 8'hFF; bus.raddr_a = 3'd0;
      sb.push_back(8'h00);
      #1;
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_a !== exp_v) begin
         miscompares++;
         $display("FAIL bypass_reg0 got=%h want=%h", bus.rdata_a, exp_v);
      end
      tick();
      bus.we = 1'b0;
      bus.in_req = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h44;
      bus.waddr = 3'd6; bus.raddr_a = 3'd6;
`ifdef WR_BYPASS_EN
      sb.push_back(8'h44);
`else
      sb.push_back(model[6]);
`endif
      #1;
      exp_v = sb.pop_front(); vectors++;
      if (bus.rdata_a !== exp_v) begin
         miscompares++;
         $display("FAIL bypass_capture got=%h want=%h", bus.rdata_a, exp_v);
      end
      tick();
      idle_inputs();
      model[6] = 8'h44;
   endtask

   task automatic test_back_to_back();
      // Consecutive writes to different registers, read back on both ports.
      for (int i = 1; i < 8; i++) wb_write(3'(i), 8'($urandom_range(0, 255)));
      for (int i = 1; i < 8; i++) begin
         bus.raddr_a = 3'(i); bus.raddr_b = 3'(8 - i);
         sb.push_back(model[i]); sb.push_back(model[8 - i]);
         #1;
         exp_v = sb.pop_front(); vectors++;
         if (bus.rdata_a !== exp_v) begin
            miscompares++;
            $display("FAIL b2b_a[%0d] got=%h want=%h", i, bus.rdata_a, exp_v);
         end
         exp_v = sb.pop_front(); vectors++;
         if (bus.rdata_b !== exp_v) begin
            miscompares++;
            $display("FAIL b2b_b[%0d] got=%h want=%h", 8 - i, bus.rdata_b, exp_v);
         end
      end
   endtask

   initial begin
      idle_inputs();
      nReset = 1'b0;
      tick();
      do_reset();
      test_reset();
      test_writeback();
      test_input_stall();
      test_direct_capture();
      test_reset_wait();
      test_out_data();
      test_bypass();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
